// File: rtl/ps2_kbd_wb.sv
// PS/2 keyboard receiver with a byte FIFO, status/control registers and a
// pipelined Wishbone slave interface (single-cycle ack, no stall).
module ps2_kbd_wb #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        stall_o,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [1:0]    csync, dsync;
  logic          cprev, fall, dbit;
  state_t        state;
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [9:0]    shreg;
  logic          frame_ok, push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          ne, full, push_ok, pop, ovf_set;
  logic          ovf, ferr, irq_en;

  logic          req, rd, wr, flush, clr;
  logic [31:0]   rdata;
  logic          unused;

  assign stall_o = 1'b0;
  assign unused  = ^{sel_i[3:1], dat_i[31:4]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csync <= 2'b11;
      dsync <= 2'b11;
      cprev <= 1'b1;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_dat};
      cprev <= csync[1];
    end
  end

  assign fall = cprev & ~csync[1];
  assign dbit = dsync[1];

  // Shift register fills from the top: after 10 samples [7:0]=data, [8]=parity, [9]=stop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      bcnt  <= '0;
      tcnt  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (fall && !dbit) begin
          state <= SHIFT;
          bcnt  <= '0;
          tcnt  <= '0;
        end
        SHIFT: if (fall) begin
          shreg <= {dbit, shreg[9:1]};
          tcnt  <= '0;
          if (bcnt == 4'd9) state <= CHECK;
          else              bcnt  <= bcnt + 4'd1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        CHECK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_ok = (^shreg[8:0]) & shreg[9];
  assign push     = (state == CHECK) & frame_ok;
  assign ferr_set = (state == CHECK) & ~frame_ok;

  assign req   = cyc_i & stb_i;
  assign rd    = req & ~we_i;
  assign wr    = req & we_i & sel_i[0];
  assign flush = wr & (adr_i == 2'd2) & dat_i[1];
  assign clr   = wr & (adr_i == 2'd1);

  assign ne      = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd & (adr_i == 2'd0) & ne;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wp] <= shreg[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // A new error in the same cycle as its W1C leaves the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf    <= 1'b0;
      ferr   <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      ovf  <= ovf_set  | (ovf  & ~(clr & dat_i[2]));
      ferr <= ferr_set | (ferr & ~(clr & dat_i[3]));
      if (wr && adr_i == 2'd2) irq_en <= dat_i[0];
    end
  end

  always_comb begin
    rdata = '0;
    case (adr_i)
      2'd0: if (ne) rdata[8:0] = {1'b1, mem[rp]};
      2'd1: begin
        rdata[4:0]  = {state != IDLE, ferr, ovf, full, ne};
        rdata[15:8] = 8'(count);
      end
      2'd2: rdata[0] = irq_en;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      irq   <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= rd ? rdata : '0;
      irq   <= irq_en & (ne | ovf | ferr);
    end
  end
endmodule

// File: doc/ps2_kbd_wb.md
PS2_KBD_WB -- requirements
Module: ps2_kbd_wb

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: receive FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 20000: clk_i cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-003 clk_i  input  1  system clock; all logic on the rising edge; one clock domain.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 cyc_i  input  1  Wishbone cycle.
REQ-006 stb_i  input  1  Wishbone strobe.
REQ-007 we_i  input  1  write enable.
REQ-008 adr_i  input  2  word address.
REQ-009 sel_i  input  4  byte selects; only sel_i[0] is used.
REQ-010 dat_i  input  32  write data.
REQ-011 dat_o  output  32  read data.
REQ-012 ack_o  output  1  acknowledge.
REQ-013 stall_o  output  1  pipeline stall; tied 0.
REQ-014 ps2_clk  input  1  asynchronous PS/2 clock.
REQ-015 ps2_dat  input  1  asynchronous PS/2 data.
REQ-016 irq  output  1  level interrupt to the CPU.

Function
REQ-017 ps2_clk and ps2_dat shall each pass through a 2-flop synchronizer reset to 1.
- A falling edge is synchronized previous 1, current 0.
REQ-018 Receive FSM states:
- IDLE: falling edge with dat=0 -> SHIFT, bit count 0; falling edge with dat=1 is ignored.
- SHIFT: one sample per falling edge: 8 data bits LSB first, then parity, then stop; after the stop sample -> CHECK.
- CHECK: one cycle, then -> IDLE.
REQ-019 In CHECK a frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd) and stop=1.
- Good frame: push the byte.
- Bad frame: set sticky FERR; no push.
REQ-020 Timeout counter:
- Counts while in SHIFT; cleared on each falling edge.
- On reaching TIMEOUT the FSM returns to IDLE and the frame is discarded; no error is flagged.
REQ-021 FIFO push when full shall drop the byte and set sticky OVF, except when a pop occurs in the same cycle; then the push succeeds and OVF is not set.
- Simultaneous push and pop are legal at any count.
REQ-022 Wishbone request accepted when cyc_i&stb_i (stall_o=0).
- ack_o asserts exactly one cycle later for one cycle per accepted request.
- Back-to-back requests are acked every cycle.
- All side effects occur in the acceptance cycle.
REQ-023 dat_o is registered: valid in the ack cycle, 0 in all other cycles.
REQ-024 adr 0 DATA:
- Read returns [7:0] head byte, [8] not-empty, all other bits 0, and pops if non-empty.
- Read when empty returns 0 with no pop.
- Writes are ignored.
REQ-025 adr 1 STATUS read bits:
- [0] not-empty, [1] full, [2] OVF, [3] FERR, [4] busy (FSM != IDLE), [15:8] count; all other bits 0.
- Write with sel_i[0]=1: a 1 in bit [2] or [3] clears that flag.
REQ-026 adr 2 CONTROL:
- Bit [0] IRQ_EN is read/write (sel_i[0]).
- Writing 1 to bit [1] flushes the FIFO; bit [1] self-clears and reads 0.
REQ-027 adr 3 shall read 0 and ignore writes.
REQ-028 irq is registered: IRQ_EN & (not-empty | OVF | FERR).
REQ-029 Same-cycle conflicts:
- Sticky set and W1C in the same cycle: set wins.
- Flush and push in the same cycle: flush wins, FIFO ends empty.

Reset
REQ-030 While rst_i=1 at a clock edge:
- FSM -> IDLE; bit and timeout counters 0.
- FIFO pointers and count 0.
- OVF, FERR, IRQ_EN cleared; synchronizers set to 1.
- ack_o, dat_o and irq are 0 on the following cycle.
REQ-031 Reset mid-frame shall discard the partial frame; the next complete frame is received normally.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1; then read adr 0 twice -> first ack one cycle after stb with dat_o=0x0000011C; second returns 0x00000000.
REQ-033 Frame 0x1C with parity 1 -> no push, STATUS=0x00000008; write 0x8 to adr 1 -> STATUS=0x00000000.
REQ-034 9 good frames 0x01..0x09, no reads, FIFO_DEPTH=8 -> STATUS[1]=1, [2]=1, [15:8]=8; 8 reads return 0x101..0x108 in order.
REQ-035 Start bit plus 4 data bits, idle TIMEOUT+5 cycles, then frame 0xF0 with parity 1 -> FIFO holds only 0xF0, FERR=0, busy=0 after the frame.
REQ-036 IRQ_EN=1, receive 0x5A -> irq=1 within 2 cycles of CHECK; read adr 0 -> irq=0 on the cycle after ack.
REQ-037 rst_i pulsed for 1 cycle mid-frame -> STATUS=0 after reset; the next frame 0x29 is read back as 0x129.
